// File: rtl/quad_7seg_scanner.sv
// Scan controller for a 4-digit 7-segment display: slot timing, dead-time blanking,
// leading-zero suppression and frame-aligned (tear-free) value updates.
//
// Ports:
//   clk, rst      clock and asynchronous active-high reset
//   valueIn       16-bit display value, nibble i on digit i (digit 0 = rightmost)
//   valueLoad     1-cycle strobe capturing valueIn into the shadow register
//   blankZeros    suppress leading zero digits (digit 0 is never suppressed)
//   displayOn     0 keeps every digit dark while scanning continues
//   numDigit      nibble for the current digit, to the segment decoder
//   digitEnable   decoder enable, high only while the current digit is lit
//   digitSelect   one-hot digit common select, polarity set by SEL_ACTIVE_LOW
//   loadAck       1-cycle pulse when the shadow value commits to the active value
module quad_7seg_scanner #(
  parameter int SCAN_DIV       = 27000,
  parameter int BLANK_CYCLES   = 270,
  parameter bit SEL_ACTIVE_LOW = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] valueIn,
  input  logic        valueLoad,
  input  logic        blankZeros,
  input  logic        displayOn,
  output logic [3:0]  numDigit,
  output logic        digitEnable,
  output logic [3:0]  digitSelect,
  output logic        loadAck
);

  localparam int CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(SCAN_DIV - 1);
  localparam logic [3:0] SEL_OFF = SEL_ACTIVE_LOW ? 4'hF : 4'h0;

  localparam logic [0:0] ST_BLANK = 1'b0;
  localparam logic [0:0] ST_SHOW  = 1'b1;

  logic [CW-1:0] slot_cnt;
  logic [CW-1:0] cnt_nxt;
  logic [1:0]    digit_idx;
  logic [1:0]    idx_nxt;
  logic [0:0]    state;
  logic [0:0]    state_nxt;
  logic [15:0]   active;
  logic [15:0]   act_nxt;
  logic [15:0]   shadow;
  logic          pending;
  logic          wrap;
  logic          boundary;
  logic          commit;
  logic [3:0]    nib_sh;
  logic          lead_zero;
  logic          supp;
  logic          lit;
  logic [3:0]    onehot;
  logic [3:0]    sel_on;

  assign wrap     = (slot_cnt == LAST);
  assign boundary = wrap && (digit_idx == 2'd3);
  assign commit   = boundary && (valueLoad || pending);
  assign cnt_nxt  = wrap ? '0 : slot_cnt + 1'b1;
  assign idx_nxt  = wrap ? digit_idx + 2'd1 : digit_idx;

  // A load arriving in the boundary cycle itself bypasses the shadow.
  always_comb begin
    act_nxt = active;
    if (boundary) begin
      if (valueLoad)
        act_nxt = valueIn;
      else if (pending)
        act_nxt = shadow;
    end
  end

  // Outputs are computed from next-cycle counters so they line up with the slot.
  generate
    if (BLANK_CYCLES == 0) begin : g_noblank
      assign state_nxt = ST_SHOW;
    end else begin : g_blank
      localparam logic [CW-1:0] BLANK_N = CW'(BLANK_CYCLES);
      assign state_nxt = (cnt_nxt < BLANK_N) ? ST_BLANK : ST_SHOW;
    end
  endgenerate

  assign nib_sh    = {idx_nxt, 2'b00};
  assign lead_zero = ((act_nxt >> nib_sh) == 16'h0);
  assign supp      = !displayOn ||
                     (blankZeros && (idx_nxt != 2'd0) && lead_zero);
  assign lit       = (state_nxt == ST_SHOW) && !supp;
  assign onehot    = 4'b0001 << idx_nxt;
  assign sel_on    = SEL_ACTIVE_LOW ? ~onehot : onehot;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_cnt  <= '0;
      digit_idx <= 2'd0;
      state     <= ST_BLANK;
      active    <= 16'h0;
      shadow    <= 16'h0;
      pending   <= 1'b0;
      loadAck   <= 1'b0;
    end else begin
      slot_cnt  <= cnt_nxt;
      digit_idx <= idx_nxt;
      state     <= state_nxt;
      active    <= act_nxt;
      loadAck   <= commit;
      if (valueLoad)
        shadow <= valueIn;
      if (boundary)
        pending <= 1'b0;
      else if (valueLoad)
        pending <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      numDigit    <= 4'h0;
      digitEnable <= 1'b0;
      digitSelect <= SEL_OFF;
    end else begin
      numDigit    <= act_nxt[nib_sh +: 4];
      digitEnable <= lit;
      digitSelect <= lit ? sel_on : SEL_OFF;
    end
  end

endmodule
